fmul_issue_arbiter: RTL and testbench

FMUL_ISSUE_ARBITER -- requirements
Module: fmul_issue_arbiter

---
 rtl/fmul_issue_arbiter_if.sv | 38 +++
 rtl/fmul_issue_arbiter.sv | 112 +++++++++++
 tb/tb_fmul_issue_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_issue_arbiter_if.sv
// Request / multiplier / response bundle for the two-requester fmul issue arbiter.
// Optional statistics ports exist only when FMUL_ARB_STATS_EN is defined.
interface fmul_issue_arbiter_if;
    logic        req_valid_0, req_valid_1;
    logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] mul_in_1, mul_in_2;
    logic [63:0] mul_out;
    logic        rsp_valid_0, rsp_valid_1;
    logic [63:0] rsp_data_0, rsp_data_1;
    logic        rsp_ready_0, rsp_ready_1;
    logic        busy;
`ifdef FMUL_ARB_STATS_EN
    logic [31:0] issue_cnt_0, issue_cnt_1, stall_cnt;
`endif

    // Arbiter side
    modport slave (
        input  req_valid_0, req_valid_1, req_a_0, req_b_0, req_a_1, req_b_1,
        input  mul_out, rsp_ready_0, rsp_ready_1,
        output req_ready_0, req_ready_1, mul_in_1, mul_in_2,
        output rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1, busy
`ifdef FMUL_ARB_STATS_EN
        , output issue_cnt_0, issue_cnt_1, stall_cnt
`endif
    );

    // Requester / multiplier / consumer side
    modport master (
        output req_valid_0, req_valid_1, req_a_0, req_b_0, req_a_1, req_b_1,
        output mul_out, rsp_ready_0, rsp_ready_1,
        input  req_ready_0, req_ready_1, mul_in_1, mul_in_2,
        input  rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1, busy
`ifdef FMUL_ARB_STATS_EN
        , input issue_cnt_0, issue_cnt_1, stall_cnt
`endif
    );
endinterface

// File: rtl/fmul_issue_arbiter.sv
// Round-robin issue of two requesters into a MUL_LAT-deep multiplier; result at handshake+MUL_LAT+2.
// Grants are credit-gated by per-requester FIFO space so results never drop; FMUL_ARB_STATS_EN adds counters.
module fmul_issue_arbiter #(
    parameter int MUL_LAT   = 10,
    parameter int RSP_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    fmul_issue_arbiter_if.slave bus
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]       vld, rsp_rdy, credit, elig, grant, push, pop, empty;
    logic [31:0]      op_a [2];
    logic [31:0]      op_b [2];
    logic [CW-1:0]    inflight [2];
    logic [CW-1:0]    count [2];
    logic [PW-1:0]    wr_ptr [2];
    logic [PW-1:0]    rd_ptr [2];
    logic [63:0]      mem [2][RSP_DEPTH];
    logic [MUL_LAT:0] pipe_vld, pipe_tag;
    logic             rr, issue, retire;

    assign vld     = {bus.req_valid_1, bus.req_valid_0};
    assign rsp_rdy = {bus.rsp_ready_1, bus.rsp_ready_0};
    assign op_a[0] = bus.req_a_0;
    assign op_b[0] = bus.req_b_0;
    assign op_a[1] = bus.req_a_1;
    assign op_b[1] = bus.req_b_1;
    assign issue   = |grant;
    assign retire  = pipe_vld[MUL_LAT];

    always_comb begin
        credit = '0;
        push   = '0;
        pop    = '0;
        empty  = '0;
        for (int i = 0; i < 2; i++) begin
            // Reserve a FIFO slot at issue time: in-flight plus stored results bound occupancy.
            credit[i] = ({1'b0, inflight[i]} + {1'b0, count[i]}) < RSP_DEPTH[CW:0];
            empty[i]  = (count[i] == '0);
            push[i]   = retire && (pipe_tag[MUL_LAT] == i[0]);
            pop[i]    = !empty[i] && rsp_rdy[i];
        end
        elig  = vld & credit;
        grant = '0;
        if (!rst) begin
            grant[0] = elig[0] && (!rr || !elig[1]);
            grant[1] = elig[1] && (rr || !elig[0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr           <= 1'b0;
            pipe_vld     <= '0;
            pipe_tag     <= '0;
            bus.mul_in_1 <= '0;
            bus.mul_in_2 <= '0;
            for (int i = 0; i < 2; i++) begin
                inflight[i] <= '0;
                count[i]    <= '0;
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
            end
        end else begin
            pipe_vld <= {pipe_vld[MUL_LAT-1:0], issue};
            pipe_tag <= {pipe_tag[MUL_LAT-1:0], grant[1]};
            if (issue) begin
                rr           <= ~grant[1];
                bus.mul_in_1 <= grant[1] ? op_a[1] : op_a[0];
                bus.mul_in_2 <= grant[1] ? op_b[1] : op_b[0];
            end
            for (int i = 0; i < 2; i++) begin
                inflight[i] <= inflight[i] + CW'(grant[i]) - CW'(push[i]);
                count[i]    <= count[i] + CW'(push[i]) - CW'(pop[i]);
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
            end
        end
    end

    // Storage needs no reset: pointers and counts define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= bus.mul_out;
        end
    end

    assign bus.req_ready_0 = grant[0];
    assign bus.req_ready_1 = grant[1];
    assign bus.rsp_valid_0 = !empty[0];
    assign bus.rsp_valid_1 = !empty[1];
    assign bus.rsp_data_0  = empty[0] ? '0 : mem[0][rd_ptr[0]];
    assign bus.rsp_data_1  = empty[1] ? '0 : mem[1][rd_ptr[1]];
    assign bus.busy        = |pipe_vld;

`ifdef FMUL_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.issue_cnt_0 <= '0;
            bus.issue_cnt_1 <= '0;
            bus.stall_cnt   <= '0;
        end else begin
            bus.issue_cnt_0 <= bus.issue_cnt_0 + 32'(grant[0]);
            bus.issue_cnt_1 <= bus.issue_cnt_1 + 32'(grant[1]);
            bus.stall_cnt   <= bus.stall_cnt + 32'(|(vld & ~credit));
        end
    end
`endif
endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// Bench for fmul_issue_arbiter: pipelined multiplier model plus a queue-based reference of outstanding work.
module tb_fmul_issue_arbiter;
    localparam int MUL_LAT   = 10;
    localparam int RSP_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fmul_issue_arbiter_if bus ();
    fmul_issue_arbiter #(.MUL_LAT(MUL_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Multiplier: product of the operand registers appears MUL_LAT cycles later.
    logic [63:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= {32'b0, bus.mul_in_1} * {32'b0, bus.mul_in_2};
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign bus.mul_out = mpipe[MUL_LAT-1];

    // Reference: every issued op waits in its requester's queue until popped; an
    // op occupies a credit from grant to pop and is visible from grant cycle + MUL_LAT + 2.
    typedef struct { logic [63:0] prod; int due; } ent_t;
    ent_t q0[$];
    ent_t q1[$];
    int cyc = 0, last_issue = -1000;
    logic m_rr = 1'b0;
    logic [31:0] m_in1 = '0, m_in2 = '0;
    logic e_rdy0, e_rdy1, e_rv0, e_rv1, e_busy;
    logic [63:0] e_d0, e_d1;
    int errors = 0, checks = 0;

    task automatic settle();
        bit el0, el1;
        @(negedge clk);
        {e_rdy0, e_rdy1, e_rv0, e_rv1, e_busy} = '0;
        e_d0 = '0;
        e_d1 = '0;
        if (!rst) begin
            el0 = bus.req_valid_0 && (q0.size() < RSP_DEPTH);
            el1 = bus.req_valid_1 && (q1.size() < RSP_DEPTH);
            e_rdy0 = el0 && (m_rr == 1'b0 || !el1);
            e_rdy1 = el1 && (m_rr == 1'b1 || !el0);
            if (q0.size() > 0) if (q0[0].due <= cyc) begin e_rv0 = 1'b1; e_d0 = q0[0].prod; end
            if (q1.size() > 0) if (q1[0].due <= cyc) begin e_rv1 = 1'b1; e_d1 = q1[0].prod; end
            e_busy = (cyc - last_issue >= 1) && (cyc - last_issue <= MUL_LAT + 1);
        end
    endtask

    task automatic advance();
        ent_t e;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_rr = 1'b0;
            m_in1 = '0;
            m_in2 = '0;
            last_issue = -1000;
        end else begin
            if (e_rv0 && bus.rsp_ready_0) void'(q0.pop_front());
            if (e_rv1 && bus.rsp_ready_1) void'(q1.pop_front());
            if (e_rdy0) begin
                e.prod = {32'b0, bus.req_a_0} * {32'b0, bus.req_b_0};
                e.due = cyc + MUL_LAT + 2;
                q0.push_back(e);
                m_rr = 1'b1; m_in1 = bus.req_a_0; m_in2 = bus.req_b_0; last_issue = cyc;
            end
            if (e_rdy1) begin
                e.prod = {32'b0, bus.req_a_1} * {32'b0, bus.req_b_1};
                e.due = cyc + MUL_LAT + 2;
                q1.push_back(e);
                m_rr = 1'b0; m_in1 = bus.req_a_1; m_in2 = bus.req_b_1; last_issue = cyc;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
    endtask

    task automatic drive_idle();
        bus.req_valid_0 = 1'b0;
        bus.req_valid_1 = 1'b0;
        bus.rsp_ready_0 = 1'b1;
        bus.rsp_ready_1 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b1;
        bus.req_a_0 = $urandom; bus.req_b_0 = $urandom;
        bus.req_a_1 = $urandom; bus.req_b_1 = $urandom;
        bus.rsp_ready_0 = 1'b1; bus.rsp_ready_1 = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if ({bus.req_ready_1, bus.req_ready_0, bus.rsp_valid_1, bus.rsp_valid_0, bus.busy} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl: got %b want 00000",
                         {bus.req_ready_1, bus.req_ready_0, bus.rsp_valid_1, bus.rsp_valid_0, bus.busy});
            end
            checks++;
            if ({bus.mul_in_1, bus.mul_in_2, bus.rsp_data_0, bus.rsp_data_1} !== 192'b0) begin
                errors++;
                $display("FAIL reset_data: mul_in=%h/%h rsp=%h/%h want all 0",
                         bus.mul_in_1, bus.mul_in_2, bus.rsp_data_0, bus.rsp_data_1);
            end
            advance();
        end
        rst = 1'b0;
        settle();
        checks++;
        if ({bus.req_ready_1, bus.req_ready_0} !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want 01", {bus.req_ready_1, bus.req_ready_0});
        end
        advance();
        drive_idle();
        for (int i = 0; i < 14; i++) begin
            settle();
            checks++;
            if ({bus.rsp_valid_0, bus.busy} !== {e_rv0, e_busy}) begin
                errors++;
                $display("FAIL reset_drain cyc=%0d: got %b want %b", cyc, {bus.rsp_valid_0, bus.busy}, {e_rv0, e_busy});
            end
            if (e_rv0) begin
                checks++;
                if (bus.rsp_data_0 !== e_d0) begin
                    errors++;
                    $display("FAIL reset_drain_data: got %h want %h", bus.rsp_data_0, e_d0);
                end
            end
            advance();
        end
    endtask

    task automatic test_single();
        drive_idle();
        bus.req_valid_0 = 1'b1; bus.req_a_0 = 32'd3; bus.req_b_0 = 32'd5;
        settle();
        checks++;
        if (bus.req_ready_0 !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got %b want 1", bus.req_ready_0);
        end
        advance();
        bus.req_valid_0 = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            settle();
            checks++;
            if (bus.busy !== (i <= MUL_LAT + 1)) begin
                errors++;
                $display("FAIL single_busy T+%0d: got %b want %b", i, bus.busy, (i <= MUL_LAT + 1));
            end
            checks++;
            if (bus.rsp_valid_0 !== (i == MUL_LAT + 2)) begin
                errors++;
                $display("FAIL single_rsp_valid T+%0d: got %b want %b", i, bus.rsp_valid_0, (i == MUL_LAT + 2));
            end
            if (i == 1) begin
                checks++;
                if ({bus.mul_in_1, bus.mul_in_2} !== {32'd3, 32'd5}) begin
                    errors++;
                    $display("FAIL single_mul_in: got %0d,%0d want 3,5", bus.mul_in_1, bus.mul_in_2);
                end
            end
            if (i == MUL_LAT + 2) begin
                checks++;
                if (bus.rsp_data_0 !== 64'd15) begin
                    errors++;
                    $display("FAIL single_data: got %0d want 15", bus.rsp_data_0);
                end
            end
            advance();
        end
    endtask

    task automatic test_contention();
        logic [63:0] exp0[$];
        logic [63:0] exp1[$];
        logic [31:0] k;
        do_reset();
        drive_idle();
        for (int i = 0; i < 8; i++) begin
            k = $urandom;
            bus.req_valid_0 = 1'b1; bus.req_a_0 = 32'd2; bus.req_b_0 = k;
            bus.req_valid_1 = 1'b1; bus.req_a_1 = 32'd3; bus.req_b_1 = k;
            settle();
            checks++;
            if ({bus.req_ready_1, bus.req_ready_0} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL contention_grant i=%0d: got %b want %b", i,
                         {bus.req_ready_1, bus.req_ready_0}, ((i % 2 == 0) ? 2'b01 : 2'b10));
            end
            if (i % 2 == 0) exp0.push_back(64'd2 * {32'b0, k});
            else            exp1.push_back(64'd3 * {32'b0, k});
            advance();
        end
        drive_idle();
        for (int i = 0; i < 16; i++) begin
            settle();
            checks++;
            if ({bus.rsp_valid_1, bus.rsp_valid_0, bus.busy} !== {e_rv1, e_rv0, e_busy}) begin
                errors++;
                $display("FAIL contention_ctrl cyc=%0d: got %b want %b", cyc,
                         {bus.rsp_valid_1, bus.rsp_valid_0, bus.busy}, {e_rv1, e_rv0, e_busy});
            end
            if (bus.rsp_valid_0 && exp0.size() > 0) begin
                checks++;
                if (bus.rsp_data_0 !== exp0[0]) begin
                    errors++;
                    $display("FAIL contention_data0: got %h want %h", bus.rsp_data_0, exp0[0]);
                end
                void'(exp0.pop_front());
            end
            if (bus.rsp_valid_1 && exp1.size() > 0) begin
                checks++;
                if (bus.rsp_data_1 !== exp1[0]) begin
                    errors++;
                    $display("FAIL contention_data1: got %h want %h", bus.rsp_data_1, exp1[0]);
                end
                void'(exp1.pop_front());
            end
            advance();
        end
        checks++;
        if (exp0.size() + exp1.size() != 0) begin
            errors++;
            $display("FAIL contention_all_returned: missing %0d want 0", exp0.size() + exp1.size());
        end
    endtask

    task automatic test_backpressure();
        int grants, pops;
        do_reset();
        drive_idle();
        bus.rsp_ready_0 = 1'b0;
        grants = 0;
        pops = 0;
        for (int i = 0; i < 24; i++) begin
            bus.req_valid_0 = 1'b1; bus.req_a_0 = $urandom; bus.req_b_0 = $urandom;
            settle();
            checks++;
            if (bus.req_ready_0 !== (i < RSP_DEPTH)) begin
                errors++;
                $display("FAIL bp_credit i=%0d: got %b want %b", i, bus.req_ready_0, (i < RSP_DEPTH));
            end
            grants += int'(bus.req_ready_0);
            advance();
        end
`ifdef FMUL_ARB_STATS_EN
        checks++;
        if ({bus.issue_cnt_0, bus.stall_cnt} !== {32'd4, 32'd20}) begin
            errors++;
            $display("FAIL bp_stats: issue_cnt_0=%0d stall_cnt=%0d want 4 20", bus.issue_cnt_0, bus.stall_cnt);
        end
`endif
        bus.rsp_ready_0 = 1'b1;
        for (int i = 0; i < 76; i++) begin
            bus.req_valid_0 = (i < 60);
            bus.req_a_0 = $urandom; bus.req_b_0 = $urandom;
            settle();
            checks++;
            if ({bus.req_ready_0, bus.rsp_valid_0, bus.busy} !== {e_rdy0, e_rv0, e_busy}) begin
                errors++;
                $display("FAIL bp_ctrl cyc=%0d: got %b want %b", cyc,
                         {bus.req_ready_0, bus.rsp_valid_0, bus.busy}, {e_rdy0, e_rv0, e_busy});
            end
            if (e_rv0) begin
                checks++;
                if (bus.rsp_data_0 !== e_d0) begin
                    errors++;
                    $display("FAIL bp_data cyc=%0d: got %h want %h", cyc, bus.rsp_data_0, e_d0);
                end
            end
            grants += int'(bus.req_ready_0);
            pops += int'(bus.rsp_valid_0);
            advance();
        end
        checks++;
        if (pops != grants) begin
            errors++;
            $display("FAIL bp_no_loss: pops=%0d want %0d", pops, grants);
        end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] exp0[$];
        do_reset();
        drive_idle();
        for (int i = 0; i < 20; i++) begin
            bus.req_valid_0 = (i < 4);
            bus.req_a_0 = $urandom; bus.req_b_0 = $urandom;
            bus.rsp_ready_0 = (i >= 14);
            settle();
            if (i < 4) begin
                checks++;
                if (bus.req_ready_0 !== 1'b1) begin
                    errors++;
                    $display("FAIL fpp_grant i=%0d: got %b want 1", i, bus.req_ready_0);
                end
                exp0.push_back({32'b0, bus.req_a_0} * {32'b0, bus.req_b_0});
            end
            if (i >= 12) begin
                checks++;
                if (bus.rsp_valid_0 !== (i <= 17)) begin
                    errors++;
                    $display("FAIL fpp_valid i=%0d: got %b want %b", i, bus.rsp_valid_0, (i <= 17));
                end
            end
            if (bus.rsp_valid_0 && bus.rsp_ready_0 && exp0.size() > 0) begin
                checks++;
                if (bus.rsp_data_0 !== exp0[0]) begin
                    errors++;
                    $display("FAIL fpp_order i=%0d: got %h want %h", i, bus.rsp_data_0, exp0[0]);
                end
                void'(exp0.pop_front());
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            bus.req_valid_0 = (i != 1); bus.req_valid_1 = (i == 1);
            bus.req_a_0 = $urandom; bus.req_b_0 = $urandom;
            bus.req_a_1 = $urandom; bus.req_b_1 = $urandom;
            settle();
            advance();
        end
        drive_idle();
        do_reset();
        for (int i = 0; i < 2 * MUL_LAT; i++) begin
            settle();
            checks++;
            if ({bus.rsp_valid_1, bus.rsp_valid_0, bus.busy} !== 3'b000) begin
                errors++;
                $display("FAIL midflight_quiet i=%0d: got %b want 000", i,
                         {bus.rsp_valid_1, bus.rsp_valid_0, bus.busy});
            end
            advance();
        end
        bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b1;
        settle();
        checks++;
        if ({bus.req_ready_1, bus.req_ready_0} !== 2'b01) begin
            errors++;
            $display("FAIL midflight_next_grant: got %b want 01", {bus.req_ready_1, bus.req_ready_0});
        end
        advance();
        drive_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 430; i++) begin
            bus.req_valid_0 = (i < 400) && ($urandom_range(0, 3) != 0);
            bus.req_valid_1 = (i < 400) && ($urandom_range(0, 3) != 0);
            bus.req_a_0 = $urandom; bus.req_b_0 = $urandom;
            bus.req_a_1 = $urandom; bus.req_b_1 = $urandom;
            bus.rsp_ready_0 = (i >= 400) || ($urandom_range(0, 2) != 0);
            bus.rsp_ready_1 = (i >= 400) || ($urandom_range(0, 2) != 0);
            settle();
            checks++;
            if ({bus.req_ready_1, bus.req_ready_0, bus.rsp_valid_1, bus.rsp_valid_0, bus.busy} !==
                {e_rdy1, e_rdy0, e_rv1, e_rv0, e_busy}) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d: got %b want %b", cyc,
                         {bus.req_ready_1, bus.req_ready_0, bus.rsp_valid_1, bus.rsp_valid_0, bus.busy},
                         {e_rdy1, e_rdy0, e_rv1, e_rv0, e_busy});
            end
            checks++;
            if ({bus.mul_in_1, bus.mul_in_2} !== {m_in1, m_in2}) begin
                errors++;
                $display("FAIL rand_mul_in cyc=%0d: got %h/%h want %h/%h", cyc, bus.mul_in_1, bus.mul_in_2, m_in1, m_in2);
            end
            if (e_rv0) begin
                checks++;
                if (bus.rsp_data_0 !== e_d0) begin
                    errors++;
                    $display("FAIL rand_data0 cyc=%0d: got %h want %h", cyc, bus.rsp_data_0, e_d0);
                end
            end
            if (e_rv1) begin
                checks++;
                if (bus.rsp_data_1 !== e_d1) begin
                    errors++;
                    $display("FAIL rand_data1 cyc=%0d: got %h want %h", cyc, bus.rsp_data_1, e_d1);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_full_push_pop();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
